// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------
// piso_pkg: shared types and sizing helpers for the piso_tx serial link sender.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------
// piso_tx: WIDTH-bit valid/ready parallel-in, serial-out transmitter with framing.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             last,
  output logic             done
);

  localparam int             CNT_W       = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;

  logic             at_last;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign at_last  = (state == SHIFT) && (bit_cnt == CNT_LAST);
  assign pi_ready = (state == IDLE) || at_last;
  assign xfer     = pi_valid && pi_ready;
  assign shifted  = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                              : {1'b0, shift_reg[WIDTH-1:1]};

  // so is registered as the head of the next shift_reg value, so it always
  // equals the head of shift_reg during the cycle it is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      so        <= 1'b0;
      so_valid  <= 1'b0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= at_last;
      if (xfer) begin
        state     <= SHIFT;
        shift_reg <= pi;
        bit_cnt   <= '0;
        so        <= head_bit(pi);
        so_valid  <= 1'b1;
        last      <= 1'b0;
      end else if (state == SHIFT && !at_last) begin
        shift_reg <= shifted;
        bit_cnt   <= bit_cnt + 1'b1;
        so        <= head_bit(shifted);
        so_valid  <= 1'b1;
        last      <= (bit_cnt == CNT_PRELAST);
      end else begin
        if (state == SHIFT) begin
          shift_reg <= shifted;
        end
        state    <= IDLE;
        so       <= 1'b0;
        so_valid <= 1'b0;
        last     <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------
// tb_piso_tx: directed self-checking bench for piso_tx (MSB-first and LSB-first).
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_piso_tx;
  import piso_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] pi = '0;
  logic         pi_valid = 1'b0;
  logic         pi_ready, so, so_valid, last, done;

  logic [W-1:0] pi_l = '0;
  logic         pi_valid_l = 1'b0;
  logic         pi_ready_l, so_l, so_valid_l, last_l, done_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .pi(pi), .pi_valid(pi_valid),
    .pi_ready(pi_ready), .so(so), .so_valid(so_valid), .last(last), .done(done)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .pi(pi_l), .pi_valid(pi_valid_l),
    .pi_ready(pi_ready_l), .so(so_l), .so_valid(so_valid_l), .last(last_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic v,
                         input logic l, input logic d);
    chk({tag, ".so"}, {31'd0, so}, {31'd0, s});
    chk({tag, ".so_valid"}, {31'd0, so_valid}, {31'd0, v});
    chk({tag, ".last"}, {31'd0, last}, {31'd0, l});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call in the first bit cycle of word w; returns in its last-bit cycle.
  task automatic expect_bits(input string tag, input logic [W-1:0] w, input logic first_done);
    for (int i = 0; i < W; i++) begin
      chk_out($sformatf("%s.b%0d", tag, i), w[W-1-i], 1'b1, (i == W-1),
              (i == 0) ? first_done : 1'b0);
      chk($sformatf("%s.ready%0d", tag, i), {31'd0, pi_ready}, (i == W-1) ? 32'd1 : 32'd0);
      if (i < W-1) step();
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_out("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Single word 1011
    pi = 4'b1011;
    pi_valid = 1'b1;
    chk("single.ready_idle", {31'd0, pi_ready}, 32'd1);
    step();
    pi_valid = 1'b0;
    pi = 4'b0000;
    expect_bits("single", 4'b1011, 1'b0);
    step();
    chk_out("single.done", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("single.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Every 4-bit value, one word at a time
    for (int v = 0; v < 16; v++) begin
      pi = W'(v);
      pi_valid = 1'b1;
      step();
      pi_valid = 1'b0;
      pi = ~W'(v);
      expect_bits($sformatf("all%0d", v), W'(v), 1'b0);
      step();
      chk_out($sformatf("all%0d.done", v), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step();

    // Back-to-back A then 5
    pi = 4'hA;
    pi_valid = 1'b1;
    step();
    pi = 4'h5;
    expect_bits("b2b_a", 4'hA, 1'b0);
    step();
    pi_valid = 1'b0;
    pi = 4'hF;
    expect_bits("b2b_5", 4'h5, 1'b1);
    step();
    chk_out("b2b.done2", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Holdoff: F offered during the 2nd bit of 3
    pi = 4'h3;
    pi_valid = 1'b1;
    step();
    pi_valid = 1'b0;
    chk_out("hold.b0", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    pi = 4'hF;
    pi_valid = 1'b1;
    chk_out("hold.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hold.ready1", {31'd0, pi_ready}, 32'd0);
    step();
    chk_out("hold.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold.ready2", {31'd0, pi_ready}, 32'd0);
    step();
    chk_out("hold.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("hold.ready3", {31'd0, pi_ready}, 32'd1);
    step();
    pi_valid = 1'b0;
    pi = 4'h0;
    expect_bits("hold_f", 4'hF, 1'b1);
    step();
    chk_out("hold.done", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Reset during the 3rd bit of C
    pi = 4'hC;
    pi_valid = 1'b1;
    step();
    pi_valid = 1'b0;
    chk_out("rst.b0", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("rst.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("rst.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst.held1", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("rst.held2", 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    pi = 4'h9;
    pi_valid = 1'b1;
    step();
    pi_valid = 1'b0;
    expect_bits("rst_9", 4'h9, 1'b0);
    step();
    chk_out("rst_9.done", 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // LSB-first instance: 1000 -> 0,0,0,1
    pi_l = 4'b1000;
    pi_valid_l = 1'b1;
    step();
    pi_valid_l = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk($sformatf("lsb.so%0d", i), {31'd0, so_l}, (i == W-1) ? 32'd1 : 32'd0);
      chk($sformatf("lsb.valid%0d", i), {31'd0, so_valid_l}, 32'd1);
      chk($sformatf("lsb.last%0d", i), {31'd0, last_l}, (i == W-1) ? 32'd1 : 32'd0);
      step();
    end
    chk("lsb.done", {31'd0, done_l}, 32'd1);
    chk("lsb.idle_valid", {31'd0, so_valid_l}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter, the sending end of the team's 4-bit serial link. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on so, with framing strobes. The default bit order (MSB first) matches the sipo receiver, so so connects directly to sipo.si.

Parameters:
WIDTH, 4, word width in bits; legal range >= 2.
MSB_FIRST, 1, 1 sends bit WIDTH-1 first (sipo-compatible); 0 sends bit 0 first.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset_n  input  1  asynchronous, active-low reset.
pi  input  WIDTH  parallel word to send; sampled only on an accepted transfer.
pi_valid  input  1  pi holds a word to send.
pi_ready  output  1  block can accept a word this cycle (combinational).
so  output  1  serial data out (registered).
so_valid  output  1  so carries a payload bit this cycle.
last  output  1  so carries the final bit of the current word.
done  output  1  one-cycle pulse: previous word fully sent.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, shift_reg=0, bit_cnt=0, so=0, so_valid=0, last=0, done=0. No transfer is accepted while reset_n is low. Release is synchronous to clk; the first accept is possible on the first clk edge after release.
- Transfer: occurs on a rising clk edge with pi_valid && pi_ready.
- pi_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1).
- FSM states:
  - IDLE: so_valid=0, so=0.
    - On transfer: shift_reg<=pi, bit_cnt<=0, go to SHIFT.
  - SHIFT: so = the current head bit of shift_reg (bit WIDTH-1 if MSB_FIRST, else bit 0); so_valid=1; last=(bit_cnt==WIDTH-1).
    - Each edge: shift toward the head, fill the vacated bit with 0, bit_cnt++.
    - At bit_cnt==WIDTH-1 with a transfer: reload shift_reg<=pi, bit_cnt<=0, stay in SHIFT. This gives back-to-back words with no idle gap.
    - At bit_cnt==WIDTH-1 without a transfer: go to IDLE.
- Latency: word accepted at edge k. Its first bit is on so during the cycle after edge k. The last bit is on so during cycle k+WIDTH. done=1 in cycle k+WIDTH+1, asserted for exactly one cycle, including in back-to-back operation.
- Throughput: one word per WIDTH cycles sustained.
- so, so_valid, last and done are driven from registers. pi_ready is the only combinational output.
- pi is ignored when no transfer occurs. pi_valid without pi_ready holds off; no word is lost or duplicated.
- bit_cnt width is clog2(WIDTH). It never exceeds WIDTH-1 and wraps to 0 only on reload.
- Reset mid-word: the word is abandoned and outputs go to reset values immediately. done is not pulsed for the abandoned word.

Decomposition:
- Package piso_pkg:
  - state enum typedef (IDLE, SHIFT);
  - function cnt_w(WIDTH) returning clog2(WIDTH);
  - localparam DEFAULT_WIDTH=4, shared with sipo benches.
- No sub-module. FSM, counter and shift register live in piso_tx; the block is small enough that splitting adds only wiring.

Test Plan:
- Reset then single word: assert/release reset_n, pi=4'b1011 with pi_valid for one cycle -> so=1,0,1,1 on the next 4 cycles; so_valid high for those 4 cycles; last high on the 4th only; done pulses the following cycle; pi_ready=0 during cycles 1-3.
- Loopback with sipo: so->si, send 4'b0110 -> sipo.po==4'b0110 two edges after the last bit is on so; repeat for all 16 values.
- Back-to-back: pi_valid held high with words 4'hA then 4'h5 -> so stream 1,0,1,0,0,1,0,1 with so_valid continuously high for 8 cycles; done pulses twice, 4 cycles apart.
- Holdoff: raise pi_valid with 4'hF during the 2nd bit of 4'h3 -> 4'hF is not accepted until the last-bit cycle; stream 0,0,1,1,1,1,1,1, no gap.
- LSB-first (MSB_FIRST=0): send 4'b1000 -> so=0,0,0,1.
- Reset mid-word: drop reset_n during the 3rd bit of 4'hC -> so, so_valid, last and done go to 0 immediately, with no done pulse. A new word 4'h9 sent after release transmits 1,0,0,1 cleanly.
